// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4-to-1 data mux with a valid/ready output.
// Each grant is capped at MAX_HOLD accepted beats before rotation.
module mux4_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] data,
    input  logic               out_ready,
    output logic [3:0]         gnt,
    output logic [1:0]         sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic               busy
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state, state_n;
    logic [1:0]    sel_n;
    logic [1:0]    ptr, ptr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    gnt_n;
    logic          beat;
    logic          rel;
    logic [1:0]    arb_ptr;
    logic [2:0]    win;

    // Returns {found, index}: first requester at or after p, wrapping 3->0.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] c;
        res = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            c = p + 2'(k);
            if (!res[2] && r[c]) res = {1'b1, c};
        end
        return res;
    endfunction

    assign busy      = (state == GRANT);
    assign out_valid = (state == GRANT) && req[sel];
    assign out_data  = data[32'(sel) * WIDTH +: WIDTH];
    assign beat      = out_valid && out_ready;
    assign rel       = (state == GRANT) &&
                       (!req[sel] || (beat && cnt == CW'(MAX_HOLD - 1)));

    // On release the arbitration uses the rotated pointer in the same edge.
    assign arb_ptr   = (state == GRANT) ? sel + 2'd1 : ptr;
    assign win       = pick(req, arb_ptr);

    always_comb begin
        state_n = state;
        sel_n   = sel;
        ptr_n   = ptr;
        cnt_n   = cnt;
        gnt_n   = gnt;
        case (state)
            IDLE: begin
                if (win[2]) begin
                    state_n = GRANT;
                    sel_n   = win[1:0];
                    gnt_n   = 4'b0001 << win[1:0];
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                if (rel) begin
                    ptr_n = arb_ptr;
                    cnt_n = '0;
                    if (win[2]) begin
                        sel_n = win[1:0];
                        gnt_n = 4'b0001 << win[1:0];
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                    end
                end else if (beat) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            ptr   <= '0;
            cnt   <= '0;
            gnt   <= '0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed stimulus queues expected beats,
// a negedge monitor pops and compares each accepted beat.
module tb_mux4_rr_arbiter;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] gnt;
        logic [7:0] data;
    } beat_t;

    logic               clk;
    logic               rst;
    logic [3:0]         req;
    logic [4*WIDTH-1:0] data;
    logic               out_ready;
    logic [3:0]         gnt;
    logic [1:0]         sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               busy;

    logic [7:0] dv [4];
    beat_t      exp_q [$];
    int         checks;
    int         errors;

    mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(4)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .data(data),
        .out_ready(out_ready),
        .gnt(gnt),
        .sel(sel),
        .out_data(out_data),
        .out_valid(out_valid),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic push_beats(input int idx, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.sel  = 2'(idx);
            b.gnt  = 4'(1) << idx;
            b.data = dv[idx];
            exp_q.push_back(b);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req       = '0;
        out_ready = 1'b0;
        rst       = 1'b1;
        step();
        rst       = 1'b0;
    endtask

    // Monitor: one scoreboard entry per beat accepted at the coming edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: got sel=%0d data=0x%0h, expected no beat", sel, out_data);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_sel", 32'(sel), 32'(e.sel));
                check("beat_gnt", 32'(gnt), 32'(e.gnt));
                check("beat_data", 32'(out_data), 32'(e.data));
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        dv[0] = 8'hC0;
        dv[1] = 8'hB1;
        dv[2] = 8'hA5;
        dv[3] = 8'hD3;
        data      = {dv[3], dv[2], dv[1], dv[0]};
        req       = '0;
        out_ready = 1'b0;
        rst       = 1'b0;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", 32'(out_data), 32'hC0);
        step();
        rst = 1'b0;

        // 1: single requester 2, one-cycle grant latency
        req = 4'b0100;
        out_ready = 1'b1;
        push_beats(2, 1);
        step();
        check("t1_gnt", 32'(gnt), 32'b0100);
        check("t1_sel", 32'(sel), 32'd2);
        check("t1_valid", 32'(out_valid), 32'h1);
        check("t1_data", 32'(out_data), 32'hA5);
        check("t1_busy", 32'(busy), 32'h1);
        step();
        req = 4'b0000;
        step();
        check("t1_idle_gnt", 32'(gnt), 32'h0);
        check("t1_idle_busy", 32'(busy), 32'h0);
        check("t1_idle_sel_hold", 32'(sel), 32'd2);
        check("t1_idle_valid", 32'(out_valid), 32'h0);
        out_ready = 1'b0;
        check("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // 2: all requesting, rotation every 4 beats with no bubble
        apply_reset();
        req = 4'b1111;
        out_ready = 1'b1;
        push_beats(0, 4);
        push_beats(1, 4);
        push_beats(2, 4);
        push_beats(3, 4);
        push_beats(0, 4);
        repeat (5) step();
        check("t2_rot_gnt", 32'(gnt), 32'b0010);
        repeat (16) step();
        out_ready = 1'b0;
        req = '0;
        check("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // 3: stall on requester 1, late request 2 must not preempt
        apply_reset();
        req = 4'b0010;
        step();
        for (int i = 0; i < 3; i++) begin
            check("t3_stall_valid", 32'(out_valid), 32'h1);
            check("t3_stall_gnt", 32'(gnt), 32'b0010);
            check("t3_stall_data", 32'(out_data), 32'hB1);
            step();
        end
        req = 4'b0110;
        out_ready = 1'b1;
        push_beats(1, 4);
        push_beats(2, 4);
        repeat (8) step();
        out_ready = 1'b0;
        req = '0;
        check("t3_q_empty", 32'(exp_q.size()), 32'd0);

        // 4: holder 3 drops after 2 beats, pending 0 wins next edge
        apply_reset();
        req = 4'b1000;
        out_ready = 1'b1;
        step();
        check("t4_gnt3", 32'(gnt), 32'b1000);
        req = 4'b1001;
        push_beats(3, 2);
        repeat (2) step();
        req = 4'b0001;
        step();
        check("t4_gnt0", 32'(gnt), 32'b0001);
        check("t4_sel0", 32'(sel), 32'd0);
        push_beats(0, 1);
        step();
        out_ready = 1'b0;
        req = '0;
        check("t4_q_empty", 32'(exp_q.size()), 32'd0);

        // 5: requesters 1 and 3 alternate
        apply_reset();
        req = 4'b1010;
        out_ready = 1'b1;
        push_beats(1, 4);
        push_beats(3, 4);
        push_beats(1, 1);
        repeat (10) step();
        out_ready = 1'b0;
        req = '0;
        check("t5_q_empty", 32'(exp_q.size()), 32'd0);

        // 6: async reset mid-burst drops the in-flight beat and restores ptr=0
        apply_reset();
        req = 4'b1111;
        out_ready = 1'b1;
        push_beats(0, 4);
        push_beats(1, 2);
        repeat (7) step();
        #2 rst = 1'b1;
        #1;
        check("t6_rst_gnt", 32'(gnt), 32'h0);
        check("t6_rst_valid", 32'(out_valid), 32'h0);
        check("t6_rst_sel", 32'(sel), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        step();
        rst = 1'b0;
        push_beats(0, 1);
        step();
        check("t6_first_gnt", 32'(gnt), 32'b0001);
        step();
        out_ready = 1'b0;
        req = '0;
        check("t6_q_empty", 32'(exp_q.size()), 32'd0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
